// File: rtl/uart_pkg.sv
// Shared constants and types for the 8N1 UART receiver.
package uart_pkg;

   localparam int                  SPEED_W       = 13;
   localparam logic [SPEED_W-1:0]  DEFAULT_SPEED = 13'd5208;
   localparam logic [SPEED_W-1:0]  MIN_SPEED     = 13'd4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   // Periods shorter than MIN_SPEED leave no room for a mid-bit sample point.
   function automatic logic [SPEED_W-1:0] clamp_speed(input logic [SPEED_W-1:0] s);
      return (s < MIN_SPEED) ? MIN_SPEED : s;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle (1).
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Two flops in series; reset to the idle-line level so no false start edge appears.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         // NOTE: non-blocking so the second flop takes the first flop's pre-edge value.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a runtime-programmable bit period. Samples each bit
// near its middle, shifts LSB first and publishes the byte on a valid stop bit.
module uart_rx
   import uart_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               rx,
   input  logic [SPEED_W-1:0] speed,
   input  logic               set_speed,
   output logic               uart_inbound,
   output logic [7:0]         data_received
);

   state_t             state;
   logic               rx_s;
   logic               rx_prev;
   logic [SPEED_W-1:0] speed_reg;
   logic [SPEED_W-1:0] frame_period;
   logic [SPEED_W-1:0] half_period;
   logic [SPEED_W-1:0] timer;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;
   logic               bit_end;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // The running frame uses frame_period, frozen at start detection.
   assign half_period = frame_period >> 1;
   assign bit_end     = (timer == frame_period - 1'b1);

   // Programmable bit period; may be reloaded at any time, clamped to the minimum.
   always_ff @(posedge clk) begin
      if (!reset) begin
         speed_reg <= DEFAULT_SPEED;
      end else if (set_speed) begin
         speed_reg <= clamp_speed(speed);
      end
   end

   // Receive FSM with bit timer, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         uart_inbound  <= 1'b0;
         data_received <= 8'h00;
         rx_prev       <= 1'b1;
         timer         <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         frame_period  <= DEFAULT_SPEED;
      end else begin
         rx_prev <= rx_s;
         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  state        <= START;
                  timer        <= '0;
                  frame_period <= speed_reg;
                  uart_inbound <= 1'b1;
               end
            end
            START: begin
               if (timer == half_period) begin
                  if (rx_s) begin
                     // Start bit did not last half a period: treat as a glitch.
                     state        <= IDLE;
                     uart_inbound <= 1'b0;
                  end else begin
                     state   <= DATA;
                     timer   <= '0;
                     bit_idx <= '0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift[bit_idx] <= rx_s;
                  timer          <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  timer        <= '0;
                  uart_inbound <= 1'b0;
                  if (rx_s) begin
                     data_received <= shift;
                     state         <= IDLE;
                  end else begin
                     state <= WAIT_IDLE;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT_IDLE: begin
               // A held break must return high before another start is accepted.
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               uart_inbound <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written
// corner sequences; received bytes are matched against a scoreboard queue.
module tb_uart_rx;
   import uart_pkg::*;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               rx = 1'b1;
   logic               set_speed = 1'b0;
   logic [SPEED_W-1:0] speed = '0;
   logic               uart_inbound;
   logic [7:0]         data_received;

   int                 checks = 0;
   int                 errors = 0;
   logic [7:0]         sb[$];
   logic [7:0]         prev_data = 8'h00;
   int                 p;

   typedef struct {
      logic [7:0] data;
      int         spd;
      bit         stop_ok;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   uart_rx dut (
      .clk           (clk),
      .reset         (reset),
      .rx            (rx),
      .speed         (speed),
      .set_speed     (set_speed),
      .uart_inbound  (uart_inbound),
      .data_received (data_received)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Advance n clocks, landing 1 ns after the rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_spd(input int v);
      speed     = SPEED_W'(v);
      set_speed = 1'b1;
      tick(1);
      set_speed = 1'b0;
   endtask

   // Drive one 8N1 frame at p clk/bit. Optionally hold a break after a bad stop
   // bit, and optionally load a new speed at the start of data bit load_bit.
   task automatic send_frame(input logic [7:0] b, input int bp, input bit stop,
                             input int hold_bits, input int load_bit, input int new_spd);
      if (stop) sb.push_back(b);
      rx = 1'b0;
      tick(bp);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == load_bit) begin
            speed     = SPEED_W'(new_spd);
            set_speed = 1'b1;
            tick(1);
            set_speed = 1'b0;
            tick(bp - 1);
         end else begin
            tick(bp);
         end
         if (i == 1) check("inbound_mid_frame", uart_inbound, 1);
      end
      rx = stop;
      tick(bp);
      if (!stop && hold_bits > 0) begin
         tick(hold_bits * bp / 2);
         check("inbound_in_break", uart_inbound, 0);
         tick(hold_bits * bp - hold_bits * bp / 2);
      end
      rx = 1'b1;
   endtask

   // Scoreboard: every update of data_received must match the oldest pending byte.
   always @(negedge clk) begin
      logic [7:0] exp_b;
      if (reset && data_received !== prev_data) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_update: got %02h expected no update", data_received);
         end else begin
            exp_b = sb.pop_front();
            check("sb_byte", data_received, exp_b);
         end
      end
      prev_data = data_received;
   end

   initial begin
      vecs[0] = '{8'hA5, 16, 1'b1, 8'hA5};
      vecs[1] = '{8'h3C, 16, 1'b0, 8'hA5};
      vecs[2] = '{8'h77,  8, 1'b1, 8'h77};
      vecs[3] = '{8'h01,  1, 1'b1, 8'h01};
      vecs[4] = '{8'hFE,  4, 1'b1, 8'hFE};
      vecs[5] = '{8'hE7, 16, 1'b0, 8'hFE};

      // Reset state
      reset = 1'b0;
      tick(3);
      check("reset_inbound", uart_inbound, 0);
      check("reset_data", data_received, 8'h00);
      check("reset_period", dut.speed_reg, 5208);
      reset = 1'b1;
      tick(2);

      // Table-driven frames, including a bad stop bit and the speed clamp
      for (int i = 0; i < 6; i++) begin
         set_spd(vecs[i].spd);
         p = (vecs[i].spd < 4) ? 4 : vecs[i].spd;
         if (vecs[i].spd < 4) check("speed_clamp", dut.speed_reg, 4);
         tick(2);
         send_frame(vecs[i].data, p, vecs[i].stop_ok, 0, -1, 0);
         tick(2 * p);
         check("vec_inbound_idle", uart_inbound, 0);
         check("vec_data", data_received, vecs[i].exp_data);
      end

      // Glitch: 4-clk low pulse at 16 clk/bit
      set_spd(16);
      tick(4);
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      check("glitch_pulse", uart_inbound, 1);
      tick(30);
      check("glitch_inbound_idle", uart_inbound, 0);
      check("glitch_data", data_received, 8'hFE);

      // Framing error followed by a 40-bit break, then a clean frame
      send_frame(8'h3C, 16, 1'b0, 40, -1, 0);
      tick(32);
      check("break_inbound", uart_inbound, 0);
      check("break_data", data_received, 8'hFE);
      send_frame(8'h81, 16, 1'b1, 0, -1, 0);
      tick(32);
      check("recover_data", data_received, 8'h81);

      // Mid-frame speed load affects only the next frame
      send_frame(8'h5A, 16, 1'b1, 0, 3, 32);
      tick(32);
      check("speedchg_cur", data_received, 8'h5A);
      send_frame(8'hC3, 32, 1'b1, 0, -1, 0);
      tick(64);
      check("speedchg_next", data_received, 8'hC3);

      // Back-to-back frames with no idle gap
      send_frame(8'h00, 32, 1'b1, 0, -1, 0);
      send_frame(8'hFF, 32, 1'b1, 0, -1, 0);
      tick(64);
      check("b2b_data", data_received, 8'hFF);

      // Reset in the middle of a frame
      rx = 1'b0;
      tick(96);
      check("abort_pre_inbound", uart_inbound, 1);
      reset = 1'b0;
      tick(3);
      check("abort_inbound", uart_inbound, 0);
      check("abort_data", data_received, 8'h00);
      check("abort_period", dut.speed_reg, 5208);
      reset = 1'b1;
      rx = 1'b1;
      tick(4);
      set_spd(16);
      tick(2);
      send_frame(8'h42, 16, 1'b1, 0, -1, 0);
      tick(32);
      check("post_abort_data", data_received, 8'h42);

      tick(10);
      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
